adder_slice_sequencer: RTL and testbench
========================================

// Module: adder_slice_sequencer
// PURPOSE
//   Multi-cycle controller that computes a WIDTH-bit add (a + b + cin) using one
//   narrow SLICE-bit ripple adder (e.g. the 2-bit FullAdder chain), least-significant
//   slice first, carrying cout of each slice into cin of the next.
//   Sits between a requester (start/done handshake) and the external adder slice,
//   which it drives and samples once per cycle. Trades latency for adder area.
// PARAMETERS
//   WIDTH  8  operand/result width in bits; must be an integer multiple of SLICE
//   SLICE  2  width of the external adder slice in bits
//   (derived) NSLICE = WIDTH/SLICE; counter width = clog2(NSLICE), min 1
// PORTS
//   clk       in   1      single clock; all state updates on rising edge
//   rst_n     in   1      synchronous reset, active low
//   start     in   1      request; accepted only in IDLE or DONE
//   a         in   WIDTH  operand A, sampled on the accept edge only
//   b         in   WIDTH  operand B, sampled on the accept edge only
//   cin       in   1      carry-in, sampled on the accept edge only
//   busy      out  1      1 while in RUN
//   done      out  1      one-cycle pulse, result valid
//   sum       out  WIDTH  registered result; holds until next accepted start
//   cout      out  1      registered final carry; holds like sum
//   add_a     out  SLICE  current slice of A to the external adder
//   add_b     out  SLICE  current slice of B to the external adder
//   add_cin   out  1      carry into the external adder
//   add_sum   in   SLICE  external adder sum (combinational from add_*)
//   add_cout  in   1      external adder carry out
// BEHAVIOUR
//   Reset (rst_n=0 at an edge): state=IDLE, busy=0, done=0, sum=0, cout=0,
//     slice counter=0, internal operand/partial/carry regs=0. Reset mid-RUN aborts
//     the operation; no done is produced for it.
//   FSM IDLE/RUN/DONE:
//     IDLE: start=1 -> latch a,b into shift regs, carry_r<=cin, cnt<=0, -> RUN.
//     RUN:  each edge: partial <= {add_sum, partial[WIDTH-1:SLICE]};
//           carry_r <= add_cout; a,b shift regs right by SLICE; cnt<=cnt+1.
//           On the edge where cnt==NSLICE-1: sum<=final partial, cout<=add_cout,
//           -> DONE. start is ignored throughout RUN.
//     DONE: done=1 for exactly this cycle. start=1 -> accept exactly as in IDLE
//           (back-to-back), -> RUN; else -> IDLE.
//   Adder drive: in RUN add_a=a_sh[SLICE-1:0], add_b=b_sh[SLICE-1:0],
//     add_cin=carry_r; in IDLE/DONE all add_* outputs = 0.
//   Latency: start accepted at edge E0 -> busy high for NSLICE cycles
//     -> done high in the cycle after edge E0+NSLICE (NSLICE+1 cycles total).
//   busy = (state==RUN); done = (state==DONE); both registered-state decodes.
//   sum/cout change only on the RUN->DONE edge and on reset; never show partials.
//   Arithmetic: {cout,sum} == a + b + cin modulo 2^(WIDTH+1); carry wraps normally.
//   Throughput: one result per NSLICE+1 cycles with start held high.
// TESTING (WIDTH=8, SLICE=2, NSLICE=4; bench models add_* as a 2-bit adder)
//   1 a=0x5A,b=0x3C,cin=0, start 1 cycle -> busy 4 cycles, done 5th cycle,
//     sum=0x96,cout=0; add_a sequence 2,2,1,1 (LSB slice first).
//   2 a=0xFF,b=0x01,cin=0 -> sum=0x00,cout=1 (carry ripples all slices);
//     a=0xFF,b=0xFF,cin=1 -> sum=0xFF,cout=1.
//   3 start held high continuously with new operands each accept -> done every
//     5th cycle, each result correct; start pulses during RUN ignored, a/b changes
//     during RUN do not alter the result.
//   4 rst_n=0 for one edge mid-RUN (after 2 slices) -> next cycle busy=0,done=0,
//     sum=0,cout=0, add_*=0; no done follows; a fresh start completes correctly.
//   5 after a completed add, idle 10 cycles with start=0 -> sum/cout stable,
//     done stays 0, add_* outputs stay 0.
//   6 random a,b,cin (>=1000 ops, random start gaps) vs a+b+cin reference model.

Source files
------------

// File: rtl/adder_slice_sequencer_if.sv
// Handshake and adder-slice bus for adder_slice_sequencer.
// slave = sequencer side, master = requester/adder side.
interface adder_slice_sequencer_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SLICE = 2
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic [SLICE-1:0] add_a;
    logic [SLICE-1:0] add_b;
    logic             add_cin;
    logic [SLICE-1:0] add_sum;
    logic             add_cout;

    modport slave (
        input  start, a, b, cin, add_sum, add_cout,
        output busy, done, sum, cout, add_a, add_b, add_cin
    );

    modport master (
        output start, a, b, cin, add_sum, add_cout,
        input  busy, done, sum, cout, add_a, add_b, add_cin
    );
endinterface

// File: rtl/adder_slice_sequencer.sv
// Multi-cycle WIDTH-bit adder built from one external SLICE-bit adder,
// LSB slice first, carry chained through carry_q.
module adder_slice_sequencer #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SLICE = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    adder_slice_sequencer_if.slave    bus
);
    localparam int unsigned NSLICE = WIDTH / SLICE;
    localparam int unsigned CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q,   state_d;
    logic [WIDTH-1:0] a_sh_q,    a_sh_d;
    logic [WIDTH-1:0] b_sh_q,    b_sh_d;
    logic [WIDTH-1:0] partial_q, partial_d;
    logic             carry_q,   carry_d;
    logic [CW-1:0]    cnt_q,     cnt_d;
    logic [WIDTH-1:0] sum_q,     sum_d;
    logic             cout_q,    cout_d;

    always_comb begin
        state_d   = state_q;
        a_sh_d    = a_sh_q;
        b_sh_d    = b_sh_q;
        partial_d = partial_q;
        carry_d   = carry_q;
        cnt_d     = cnt_q;
        sum_d     = sum_q;
        cout_d    = cout_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    a_sh_d  = bus.a;
                    b_sh_d  = bus.b;
                    carry_d = bus.cin;
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                // New slice enters at the top; after NSLICE steps the result is aligned.
                partial_d                    = partial_q >> SLICE;
                partial_d[WIDTH-1 -: SLICE]  = bus.add_sum;
                a_sh_d  = a_sh_q >> SLICE;
                b_sh_d  = b_sh_q >> SLICE;
                carry_d = bus.add_cout;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CW'(NSLICE - 1)) begin
                    sum_d   = partial_d;
                    cout_d  = bus.add_cout;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            a_sh_q    <= '0;
            b_sh_q    <= '0;
            partial_q <= '0;
            carry_q   <= 1'b0;
            cnt_q     <= '0;
            sum_q     <= '0;
            cout_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_sh_q    <= a_sh_d;
            b_sh_q    <= b_sh_d;
            partial_q <= partial_d;
            carry_q   <= carry_d;
            cnt_q     <= cnt_d;
            sum_q     <= sum_d;
            cout_q    <= cout_d;
        end
    end

    assign bus.busy    = (state_q == RUN);
    assign bus.done    = (state_q == DONE);
    assign bus.sum     = sum_q;
    assign bus.cout    = cout_q;
    assign bus.add_a   = (state_q == RUN) ? a_sh_q[SLICE-1:0] : '0;
    assign bus.add_b   = (state_q == RUN) ? b_sh_q[SLICE-1:0] : '0;
    assign bus.add_cin = (state_q == RUN) ? carry_q : 1'b0;
endmodule

// File: tb/tb_adder_slice_sequencer.sv
// Randomized bench for adder_slice_sequencer against a transaction-level
// model: cycles-since-accept plus a + b + cin arithmetic.
module tb_adder_slice_sequencer;
    localparam int unsigned WIDTH  = 8;
    localparam int unsigned SLICE  = 2;
    localparam int          NSLICE = WIDTH / SLICE;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;
    logic chk_en;

    adder_slice_sequencer_if #(.WIDTH(WIDTH), .SLICE(SLICE)) bus ();

    adder_slice_sequencer #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // External 2-bit slice adder.
    assign {bus.add_cout, bus.add_sum} = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {2'b00, bus.add_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: k = edges since accept (-1 = no operation in flight).
    int         k;
    logic [7:0] la, lb;
    logic       lc;
    logic [7:0] esum;
    logic       ecout;

    always @(posedge clk) begin
        if (!rst_n) begin
            k <= -1; la <= '0; lb <= '0; lc <= 1'b0; esum <= '0; ecout <= 1'b0;
        end else if (k >= 0 && k < NSLICE - 1) begin
            k <= k + 1;
        end else if (k == NSLICE - 1) begin
            k <= NSLICE;
            {ecout, esum} <= {1'b0, la} + {1'b0, lb} + {8'd0, lc};
        end else if (bus.start) begin
            k <= 0; la <= bus.a; lb <= bus.b; lc <= bus.cin;
        end else begin
            k <= -1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            int   sh;
            int   mask;
            logic exp_busy;
            int   ea, eb, ec;
            exp_busy = (k >= 0 && k < NSLICE);
            ea = 0; eb = 0; ec = 0;
            if (exp_busy) begin
                sh   = k * SLICE;
                mask = (1 << sh) - 1;
                ea   = (int'(la) >> sh) & 3;
                eb   = (int'(lb) >> sh) & 3;
                ec   = ((int'(la) & mask) + (int'(lb) & mask) + int'(lc)) >> sh;
            end
            check("busy",    32'(bus.busy),    32'(exp_busy));
            check("done",    32'(bus.done),    32'(k == NSLICE));
            check("sum",     32'(bus.sum),     32'(esum));
            check("cout",    32'(bus.cout),    32'(ecout));
            check("add_a",   32'(bus.add_a),   32'(ea));
            check("add_b",   32'(bus.add_b),   32'(eb));
            check("add_cin", 32'(bus.add_cin), 32'(ec));
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Called 2 time units after an edge, with the DUT in IDLE or DONE.
    task automatic do_op(input logic [7:0] av, input logic [7:0] bv, input logic ci);
        logic ok;
        bus.start = 1'b1; bus.a = av; bus.b = bv; bus.cin = ci;
        step();
        ok = 1'b0;
        for (int unsigned i = 0; i < 20 && !ok; i++) begin
            bus.start = 1'($urandom);
            bus.a     = 8'($urandom);
            bus.b     = 8'($urandom);
            bus.cin   = 1'($urandom);
            step();
            if (bus.done) ok = 1'b1;
        end
        bus.start = 1'b0;
        if (!ok) check("done_timeout", 32'(ok), 32'd1);
    endtask

    initial begin
        n_vec = 0; n_err = 0; chk_en = 1'b0;
        rst_n = 1'b0;
        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
        step();
        step();
        chk_en = 1'b1;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_sum",  32'(bus.sum),  32'd0);
        rst_n = 1'b1;
        step();

        do_op(8'h5A, 8'h3C, 1'b0);
        check("t1_sum",  32'(bus.sum),  32'h96);
        check("t1_cout", 32'(bus.cout), 32'd0);
        step();
        do_op(8'hFF, 8'h01, 1'b0);
        check("t2a_sum",  32'(bus.sum),  32'h00);
        check("t2a_cout", 32'(bus.cout), 32'd1);
        do_op(8'hFF, 8'hFF, 1'b1);
        check("t2b_sum",  32'(bus.sum),  32'hFF);
        check("t2b_cout", 32'(bus.cout), 32'd1);

        // Start held high, operands changing every cycle.
        bus.start = 1'b1;
        for (int unsigned i = 0; i < 30; i++) begin
            bus.a = 8'($urandom); bus.b = 8'($urandom); bus.cin = 1'($urandom);
            step();
        end
        bus.start = 1'b0;
        repeat (6) step();

        // Reset after two slices of an operation.
        bus.start = 1'b1; bus.a = 8'hA7; bus.b = 8'h6E; bus.cin = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("t4_busy", 32'(bus.busy), 32'd0);
        check("t4_sum",  32'(bus.sum),  32'd0);
        repeat (8) step();
        do_op(8'h12, 8'h34, 1'b1);
        check("t4_sum2", 32'(bus.sum), 32'h47);

        // Idle hold.
        repeat (10) step();
        check("t5_sum", 32'(bus.sum), 32'h47);

        for (int unsigned n = 0; n < 1000; n++) begin
            int unsigned gap;
            gap = $urandom_range(0, 3);
            for (int unsigned g = 0; g < gap; g++) step();
            do_op(8'($urandom), 8'($urandom), 1'($urandom));
        end
        repeat (4) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
